// File: rtl/sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// sub_bytes_seq
//
// Sequential AES SubBytes stage. A 128-bit state is accepted over a
// valid/ready handshake, its 16 bytes are streamed LANES at a time through
// LANES sbox lookups, and the substituted state is offered on a second
// valid/ready handshake. Fewer lanes means fewer sboxes but a longer latency
// (16/LANES cycles from accept to out_valid).
//
// Parameters
//   LANES      bytes substituted per cycle; one of 1, 2, 4, 8, 16
//
// Ports
//   clk        in   1    sole clock, rising edge
//   rst_n      in   1    asynchronous, active-low reset
//   in_valid   in   1    in_state valid
//   in_ready   out  1    block can accept in_state (high only in IDLE)
//   in_state   in   128  input state, byte i = in_state[127-8i -: 8]
//   out_valid  out  1    out_state valid (high only in DONE)
//   out_ready  in   1    downstream accepts out_state
//   out_state  out  128  substituted state, same byte order
//   busy       out  1    high while bytes are being substituted
//
// Build option
//   SUBBYTES_SHIFTROWS_EN  when defined, ShiftRows is folded into the
//                          out_state capture at no extra latency:
//                          out byte (r,c) = sub byte (r,(c+r)%4), i = r+4c.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// SubBytesSbox
//
// Combinational AES forward sbox lookup (FIPS-197 table).
//
// Ports
//   data_i     in   8    byte to substitute
//   data_o     out  8    substituted byte
// ---------------------------------------------------------------------------
module SubBytesSbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Element 0 sits at the most significant end, so the table reads in the
    // same row/column order as the printed FIPS-197 sbox.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Pure table lookup; the byte value is the table index.
    assign data_o = SBOX_TABLE[data_i];

endmodule

module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    // Refuse to elaborate with a lane count that does not tile the 16 bytes.
    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gBadLanes
            $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q;
    logic [4:0]         idx_q;
    logic [0:15][7:0]   srcBytes_q;
    logic [0:15][7:0]   dstBytes_q;
    logic [0:15][7:0]   dstBytes_d;
    logic [0:15][7:0]   captureBytes;
    logic [127:0]       outState_q;
    logic               inReady_q;
    logic               outValid_q;
    logic               busy_q;
    logic               lastBeat;

    logic [3:0]         laneIdx [LANES];
    logic [7:0]         laneOut [LANES];

    // One sbox per lane. Lane g handles byte idx+g of the latched source;
    // idx is a multiple of LANES below 16, so the low four bits never carry.
    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : gLane
            assign laneIdx[g] = idx_q[3:0] + 4'(g);

            SubBytesSbox uSbox (
                .data_i (srcBytes_q[laneIdx[g]]),
                .data_o (laneOut[g])
            );
        end
    endgenerate

    // Next destination image: the bytes of this beat merged over what the
    // earlier beats already wrote. The capture into out_state uses this
    // merged image so the final beat's bytes land without an extra cycle.
    always_comb begin
        dstBytes_d = dstBytes_q;
        for (int l = 0; l < LANES; l++) begin
            dstBytes_d[laneIdx[l]] = laneOut[l];
        end
    end

    // The last beat is the one whose lanes reach byte 15.
    assign lastBeat = (idx_q + 5'(LANES)) == 5'd16;

`ifdef SUBBYTES_SHIFTROWS_EN
    // Byte i = r + 4c of the result takes row r from column (c + r) % 4,
    // i.e. row r is rotated left by r positions.
    function automatic logic [0:15][7:0] shiftRows(input logic [0:15][7:0] b);
        logic [0:15][7:0] res;
        res = b;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[r + 4 * c] = b[r + 4 * ((c + r) % 4)];
            end
        end
        return res;
    endfunction

    assign captureBytes = shiftRows(dstBytes_d);
`else
    assign captureBytes = dstBytes_d;
`endif

    // Control FSM with registered handshake outputs. in_ready rises on the
    // first edge after reset release and on the out transfer edge, so it is
    // guaranteed low while rst_n is asserted. A reset in BUSY or DONE
    // discards the partial result and returns everything to reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 5'd0;
            srcBytes_q <= '0;
            dstBytes_q <= '0;
            outState_q <= '0;
            inReady_q  <= 1'b0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    inReady_q <= 1'b1;
                    if (in_valid && inReady_q) begin
                        srcBytes_q <= in_state;
                        idx_q      <= 5'd0;
                        inReady_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= BUSY;
                    end
                end

                BUSY: begin
                    dstBytes_q <= dstBytes_d;
                    idx_q      <= idx_q + 5'(LANES);
                    if (lastBeat) begin
                        outState_q <= captureBytes;
                        outValid_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end

                default: begin
                    inReady_q  <= 1'b0;
                    outValid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_state = outState_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// tb_sub_bytes_seq
//
// Directed bench for sub_bytes_seq. Three instances share clock and reset:
// index 0 uses LANES=4, index 1 LANES=1, index 2 LANES=16. Expected states
// are hand-computed from the FIPS-197 sbox and the Appendix B round 1 vector.
// ---------------------------------------------------------------------------
module tb_sub_bytes_seq;

    localparam logic [127:0] ALL_00   = 128'h00000000000000000000000000000000;
    localparam logic [127:0] ALL_63   = 128'h63636363636363636363636363636363;
    localparam logic [127:0] ALL_FF   = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] ALL_16   = 128'h16161616161616161616161616161616;
    localparam logic [127:0] ALL_53   = 128'h53535353535353535353535353535353;
    localparam logic [127:0] ALL_ED   = 128'hedededededededededededededededed;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`ifdef SUBBYTES_SHIFTROWS_EN
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FF_OUT   = 128'h16161616161616161616161616161616;
`else
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FF_OUT   = 128'h16161616161616161616161616161616;
`endif

    logic         clk;
    logic         rst_n;
    logic         inValid  [3];
    logic         inReady  [3];
    logic [127:0] inState  [3];
    logic         outValid [3];
    logic         outReady [3];
    logic [127:0] outState [3];
    logic         busy     [3];

    int checks;
    int failures;

    // 10 ns clock; stimulus is driven on the falling edge or 1 ns after the
    // rising edge, never on the rising edge itself.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    sub_bytes_seq #(.LANES(4)) dutLanes4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid[0]),
        .in_ready  (inReady[0]),
        .in_state  (inState[0]),
        .out_valid (outValid[0]),
        .out_ready (outReady[0]),
        .out_state (outState[0]),
        .busy      (busy[0])
    );

    sub_bytes_seq #(.LANES(1)) dutLanes1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid[1]),
        .in_ready  (inReady[1]),
        .in_state  (inState[1]),
        .out_valid (outValid[1]),
        .out_ready (outReady[1]),
        .out_state (outState[1]),
        .busy      (busy[1])
    );

    sub_bytes_seq #(.LANES(16)) dutLanes16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid[2]),
        .in_ready  (inReady[2]),
        .in_state  (inState[2]),
        .out_valid (outValid[2]),
        .out_ready (outReady[2]),
        .out_state (outState[2]),
        .busy      (busy[2])
    );

    // One comparison: counts it, and on a miss counts the failure and
    // reports tag, observed and expected values.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Offers one state to instance d and returns 1 ns after the accepting
    // edge with in_valid dropped again. Gives up after 40 cycles.
    task automatic applyStimulus(input int d, input logic [127:0] st, input string tag);
        bit accepted;
        accepted = 1'b0;
        @(negedge clk);
        inState[d] = st;
        inValid[d] = 1'b1;
        for (int k = 0; k < 40 && !accepted; k++) begin
            if (inReady[d] === 1'b1) begin
                @(posedge clk);
                #1;
                inValid[d] = 1'b0;
                accepted = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!accepted) begin
            inValid[d] = 1'b0;
            checkOutput({tag, "_accept_timeout"}, 128'(accepted), 128'd1);
        end
    endtask

    // Counts rising edges from the accept edge until out_valid is seen,
    // then compares the count with the expected latency.
    task automatic waitResult(input int d, input int expLatency, input string tag);
        int lat;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (outValid[d] === 1'b1) break;
        end
        checkOutput({tag, "_latency"}, 128'(lat), 128'(expLatency));
    endtask

    // Completes the output transfer; in_ready must be back right after it.
    task automatic drainResult(input int d, input string tag);
        outReady[d] = 1'b1;
        @(posedge clk);
        #1;
        outReady[d] = 1'b0;
        checkOutput({tag, "_in_ready_after_out"}, 128'(inReady[d]), 128'd1);
        checkOutput({tag, "_out_valid_after_out"}, 128'(outValid[d]), 128'd0);
    endtask

    // Holds in_valid and out_ready high and counts the cycles in which the
    // block refuses input between two consecutive accepts.
    task automatic backToBack(input int d, input int expGap, input string tag);
        int accepts;
        int lowCycles;
        accepts   = 0;
        lowCycles = 0;
        @(negedge clk);
        inState[d]  = ALL_FF;
        inValid[d]  = 1'b1;
        outReady[d] = 1'b1;
        for (int k = 0; k < 100 && accepts < 2; k++) begin
            if (inReady[d] === 1'b1) begin
                accepts++;
                if (accepts == 2) inValid[d] = 1'b0;
            end else if (accepts == 1) begin
                lowCycles++;
            end
            if (accepts < 2) @(negedge clk);
        end
        inValid[d] = 1'b0;
        checkOutput({tag, "_accepts"}, 128'(accepts), 128'd2);
        checkOutput({tag, "_refused_cycles"}, 128'(lowCycles), 128'(expGap));
        repeat (3) @(negedge clk);
        outReady[d] = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inValid[i]  = 1'b0;
            outReady[i] = 1'b0;
            inState[i]  = ALL_00;
        end

        // Reset held for two cycles: everything at reset values.
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 128'(inReady[0]), 128'd0);
        checkOutput("reset_out_valid", 128'(outValid[0]), 128'd0);
        checkOutput("reset_busy", 128'(busy[0]), 128'd0);
        checkOutput("reset_out_state", outState[0], ALL_00);
        checkOutput("reset_in_ready_l1", 128'(inReady[1]), 128'd0);
        checkOutput("reset_in_ready_l16", 128'(inReady[2]), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_in_ready", 128'(inReady[0]), 128'd1);
        checkOutput("release_in_ready_l1", 128'(inReady[1]), 128'd1);
        checkOutput("release_in_ready_l16", 128'(inReady[2]), 128'd1);

        // All-zero state, LANES=4: four beats, every byte becomes 63.
        $display("[TB] zero state, LANES=4");
        applyStimulus(0, ALL_00, "zero");
        checkOutput("zero_busy", 128'(busy[0]), 128'd1);
        checkOutput("zero_in_ready_busy", 128'(inReady[0]), 128'd0);
        waitResult(0, 4, "zero");
        checkOutput("zero_out_state", outState[0], ALL_63);
        checkOutput("zero_busy_done", 128'(busy[0]), 128'd0);
        drainResult(0, "zero");

        // FIPS-197 Appendix B round 1 SubBytes vector.
        $display("[TB] FIPS-197 round 1 vector, LANES=4");
        applyStimulus(0, FIPS_IN, "fips");
        inState[0] = ALL_53;
        waitResult(0, 4, "fips");
        checkOutput("fips_out_state", outState[0], FIPS_OUT);
        drainResult(0, "fips");

        // Backpressure: ten cycles in DONE with out_ready low while a new
        // state is offered; output stays put and nothing is accepted.
        $display("[TB] backpressure, LANES=4");
        applyStimulus(0, ALL_FF, "bp");
        waitResult(0, 4, "bp");
        inState[0] = ALL_00;
        inValid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_out_state_held", outState[0], FF_OUT);
            checkOutput("bp_in_ready_low", 128'(inReady[0]), 128'd0);
            checkOutput("bp_out_valid_held", 128'(outValid[0]), 128'd1);
        end
        inValid[0] = 1'b0;
        drainResult(0, "bp");

        // Reset pulse after two beats of a block aborts it.
        $display("[TB] reset mid-BUSY, LANES=4");
        applyStimulus(0, ALL_00, "abort");
        repeat (2) @(posedge clk);
        #2;
        checkOutput("abort_busy_before", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", 128'(inReady[0]), 128'd0);
        checkOutput("abort_out_valid", 128'(outValid[0]), 128'd0);
        checkOutput("abort_busy", 128'(busy[0]), 128'd0);
        checkOutput("abort_out_state", outState[0], ALL_00);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, ALL_53, "after_abort");
        waitResult(0, 4, "after_abort");
        checkOutput("after_abort_out_state", outState[0], ALL_ED);
        drainResult(0, "after_abort");

        // LANES=1 and LANES=16 instances.
        $display("[TB] LANES=1 and LANES=16 sweeps");
        applyStimulus(1, ALL_FF, "l1");
        waitResult(1, 16, "l1");
        checkOutput("l1_out_state", outState[1], ALL_16);
        drainResult(1, "l1");
        applyStimulus(2, ALL_FF, "l16");
        waitResult(2, 1, "l16");
        checkOutput("l16_out_state", outState[2], ALL_16);
        drainResult(2, "l16");
        applyStimulus(1, FIPS_IN, "l1_fips");
        waitResult(1, 16, "l1_fips");
        checkOutput("l1_fips_out_state", outState[1], FIPS_OUT);
        drainResult(1, "l1_fips");
        applyStimulus(2, FIPS_IN, "l16_fips");
        waitResult(2, 1, "l16_fips");
        checkOutput("l16_fips_out_state", outState[2], FIPS_OUT);
        drainResult(2, "l16_fips");

        // Back-to-back traffic: between accepts the block is closed for
        // 16/LANES cycles of BUSY plus one cycle of DONE.
        backToBack(0, 5, "b2b_l4");
        backToBack(1, 17, "b2b_l1");
        backToBack(2, 2, "b2b_l16");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
